// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frames P_DATA as start, LSB-first data, optional
// parity and stop, one bit per CLK, with strobes to an external parity calculator.
module uart_tx_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] P_DATA,
  input  logic              DATA_VLD,
  input  logic              PAR_EN,
  input  logic              PAR_BIT,
  output logic              PAR_LOAD,
  output logic              PAR_FLAG,
  output logic              TX_OUT,
  output logic              BUSY
);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt;
  logic              par_en_q;
  logic              tx_nxt, busy_nxt;

  // RST gates the load strobe so nothing is loaded while held in reset
  assign PAR_LOAD = DATA_VLD & (state == IDLE) & RST;
  assign PAR_FLAG = (state == START);

  always_comb begin
    state_nxt = state;
    tx_nxt    = 1'b1;
    busy_nxt  = 1'b1;
    case (state)
      IDLE:    if (DATA_VLD) state_nxt = START;
      START:   state_nxt = DATA;
      DATA:    if (cnt == CNT_LAST) state_nxt = par_en_q ? PARITY : STOP;
      PARITY:  state_nxt = STOP;
      STOP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Line is decoded from the next state; shreg[0] is the bit on the line now
    case (state_nxt)
      IDLE:    busy_nxt = 1'b0;
      START:   tx_nxt   = 1'b0;
      DATA:    tx_nxt   = (state == DATA) ? shreg[1] : shreg[0];
      PARITY:  tx_nxt   = PAR_BIT;
      default: tx_nxt   = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      shreg    <= '0;
      cnt      <= '0;
      par_en_q <= 1'b0;
      TX_OUT   <= 1'b1;
      BUSY     <= 1'b0;
    end else begin
      state  <= state_nxt;
      TX_OUT <= tx_nxt;
      BUSY   <= busy_nxt;
      case (state)
        IDLE: if (DATA_VLD) begin
          shreg    <= P_DATA;
          par_en_q <= PAR_EN;
          cnt      <= '0;
        end
        START: cnt <= '0;
        DATA: begin
          shreg <= shreg >> 1;
          cnt   <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: per-cycle expected line/busy/flag values
// are queued when a frame is requested and popped each cycle.
module tb_uart_tx_ctrl;
  localparam int DATA_W = 8;

  logic              CLK = 1'b0;
  logic              RST;
  logic [DATA_W-1:0] P_DATA;
  logic              DATA_VLD, PAR_EN, PAR_BIT;
  logic              PAR_LOAD, PAR_FLAG, TX_OUT, BUSY;

  typedef struct packed {
    logic tx;
    logic busy;
    logic flag;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  uart_tx_ctrl #(.DATA_W(DATA_W)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VLD(DATA_VLD),
    .PAR_EN(PAR_EN), .PAR_BIT(PAR_BIT), .PAR_LOAD(PAR_LOAD),
    .PAR_FLAG(PAR_FLAG), .TX_OUT(TX_OUT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic obs, input logic expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic push_frame(input logic [DATA_W-1:0] d, input logic pen, input logic pbit);
    exp_q.push_back('{tx: 1'b0, busy: 1'b1, flag: 1'b1});
    for (int i = 0; i < DATA_W; i++) exp_q.push_back('{tx: d[i], busy: 1'b1, flag: 1'b0});
    if (pen) exp_q.push_back('{tx: pbit, busy: 1'b1, flag: 1'b0});
    exp_q.push_back('{tx: 1'b1, busy: 1'b1, flag: 1'b0});
  endtask

  // One cycle: check at negedge against the next queued entry (idle if empty),
  // then return 1 time unit after the following rising edge.
  task automatic cyc(input string tag);
    exp_t e;
    @(negedge CLK);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '{tx: 1'b1, busy: 1'b0, flag: 1'b0};
    chk({tag, ".tx"}, TX_OUT, e.tx);
    chk({tag, ".busy"}, BUSY, e.busy);
    chk({tag, ".flag"}, PAR_FLAG, e.flag);
    chk({tag, ".load"}, PAR_LOAD, DATA_VLD & ~e.busy);
    @(posedge CLK);
    #1;
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag);
  endtask

  // Drive a one-cycle request from idle; the frame starts on the next edge.
  task automatic send(input string tag, input logic [DATA_W-1:0] d, input logic pen, input logic pbit);
    P_DATA = d; PAR_EN = pen; PAR_BIT = pbit; DATA_VLD = 1'b1;
    cyc({tag, ".req"});
    push_frame(d, pen, pbit);
    DATA_VLD = 1'b0;
    P_DATA = ~d; PAR_EN = ~pen;
  endtask

  initial begin
    RST = 1'b0; P_DATA = '0; DATA_VLD = 1'b0; PAR_EN = 1'b0; PAR_BIT = 1'b0;
    #12;
    chk("rst.tx", TX_OUT, 1'b1);
    chk("rst.busy", BUSY, 1'b0);
    DATA_VLD = 1'b1;
    #1;
    chk("rst.load", PAR_LOAD, 1'b0);
    chk("rst.flag", PAR_FLAG, 1'b0);
    DATA_VLD = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    run("idle", 2);

    // A5 without parity: 10-cycle frame
    send("a5", 8'hA5, 1'b0, 1'b0);
    run("a5", 12);

    // 03 with even and odd parity bits, inputs changed after acceptance
    send("par0", 8'h03, 1'b1, 1'b0);
    run("par0", 13);
    send("par1", 8'h03, 1'b1, 1'b1);
    run("par1", 13);

    // FF request pulsed mid-frame of 00 is ignored
    send("ign", 8'h00, 1'b0, 1'b0);
    run("ign", 4);
    P_DATA = 8'hFF; DATA_VLD = 1'b1;
    cyc("ign.pulse");
    DATA_VLD = 1'b0;
    run("ign", 10);

    // DATA_VLD held high: frames separated by one idle cycle
    P_DATA = 8'h55; PAR_EN = 1'b0; DATA_VLD = 1'b1;
    cyc("b2b.req");
    push_frame(8'h55, 1'b0, 1'b0);
    exp_q.push_back('{tx: 1'b1, busy: 1'b0, flag: 1'b0});
    push_frame(8'h55, 1'b0, 1'b0);
    exp_q.push_back('{tx: 1'b1, busy: 1'b0, flag: 1'b0});
    push_frame(8'h55, 1'b0, 1'b0);
    run("b2b", 31);
    DATA_VLD = 1'b0;
    run("b2b", 4);

    // Reset during the 4th data bit aborts the frame asynchronously
    send("abort", 8'hA5, 1'b0, 1'b0);
    run("abort", 4);
    #2;
    RST = 1'b0;
    #1;
    chk("abort.tx", TX_OUT, 1'b1);
    chk("abort.busy", BUSY, 1'b0);
    chk("abort.flag", PAR_FLAG, 1'b0);
    exp_q.delete();
    @(posedge CLK); #1;
    RST = 1'b1;
    run("post", 2);
    send("post", 8'hA5, 1'b0, 1'b0);
    run("post", 12);

    chk("q.empty", exp_q.size() == 0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
